// File: rtl/eth_pkg.sv
// eth_pkg: shared FSM/grant encodings and default 125 MHz timing for the TX scheduler
package eth_pkg;
  typedef enum logic [2:0] {IDLE, ARP_REQ, ARP_WAIT, ARB, UDP_REQ, UDP_WAIT, GAP} state_t;
  typedef enum logic {GRANT_CMD = 1'b0, GRANT_AD = 1'b1} grant_t;
  localparam logic [15:0] DEF_AD_PKT_LEN  = 16'd1024;
  localparam logic [15:0] DEF_IFG_CYCLES  = 16'd24;
  localparam logic [31:0] DEF_ARP_TIMEOUT = 32'd125000000;
  localparam logic [3:0]  DEF_ARP_RETRY   = 4'd3;
  localparam logic [31:0] DEF_TX_TIMEOUT  = 32'd1000000;
endpackage

// File: rtl/eth_rr_arb.sv
// eth_rr_arb: 2-way round-robin arbiter; history advances only on a completed send
module eth_rr_arb
  import eth_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_cmd_i,
  input  logic   req_ad_i,
  input  logic   upd_i,
  input  grant_t upd_grant_i,
  output logic   gnt_valid_o,
  output grant_t gnt_o
);
  grant_t last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= GRANT_AD;
    else if (upd_i) last_q <= upd_grant_i;
  assign gnt_valid_o = req_cmd_i | req_ad_i;
  assign gnt_o = (req_cmd_i && req_ad_i) ? (last_q == GRANT_CMD ? GRANT_AD : GRANT_CMD)
               : (req_cmd_i ? GRANT_CMD : GRANT_AD);
endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: ARP-gated scheduler sharing the MAC UDP transmit path between command and AD data
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter logic [15:0] AD_PKT_LEN  = DEF_AD_PKT_LEN,
  parameter logic [15:0] IFG_CYCLES  = DEF_IFG_CYCLES,
  parameter logic [31:0] ARP_TIMEOUT = DEF_ARP_TIMEOUT,
  parameter logic [3:0]  ARP_RETRY   = DEF_ARP_RETRY,
  parameter logic [31:0] TX_TIMEOUT  = DEF_TX_TIMEOUT
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_reply_req,
  input  logic [15:0] cmd_send_len,
  output logic        cmd_reply_ack,
  input  logic        ad_data_req,
  output logic        ad_data_ack,
  output logic        udp_tx_req,
  output logic        arp_request_req,
  output logic [15:0] udp_send_data_length,
  output logic        sel_cmd,
  input  logic        mac_send_end,
  input  logic        mac_not_exist,
  input  logic        arp_found,
  output logic        arp_fail,
  output logic        tx_timeout,
  output logic        busy
);
  state_t      state_q, state_d;
  grant_t      grant_q, grant_d, arb_gnt;
  logic        arp_ok_q, arp_ok_d, arp_fail_q, arp_fail_d, sel_q, sel_d;
  logic        cmd_ack_q, cmd_ack_d, ad_ack_q, ad_ack_d, arb_valid, done;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] gap_q, gap_d, len_q, len_d;

  assign done = state_q == UDP_WAIT && mac_send_end;

  eth_rr_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_cmd_i   (cmd_reply_req),
    .req_ad_i    (ad_data_req),
    .upd_i       (done),
    .upd_grant_i (grant_q),
    .gnt_valid_o (arb_valid),
    .gnt_o       (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= GRANT_AD;
      arp_ok_q   <= 1'b0;
      arp_fail_q <= 1'b0;
      sel_q      <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ad_ack_q   <= 1'b0;
      timer_q    <= '0;
      retry_q    <= '0;
      gap_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      arp_ok_q   <= arp_ok_d;
      arp_fail_q <= arp_fail_d;
      sel_q      <= sel_d;
      cmd_ack_q  <= cmd_ack_d;
      ad_ack_q   <= ad_ack_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      len_q      <= len_d;
    end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    arp_ok_d   = arp_ok_q;
    arp_fail_d = arp_fail_q & ~arp_found;
    sel_d      = sel_q;
    len_d      = len_q;
    cmd_ack_d  = 1'b0;
    ad_ack_d   = 1'b0;
    tx_timeout = 1'b0;
    retry_d    = retry_q;
    timer_d    = timer_q + {31'd0, ~&timer_q};
    gap_d      = state_q == GAP ? gap_q + 16'd1 : 16'd0;
    case (state_q)
      IDLE: if (cmd_reply_req || ad_data_req) state_d = arp_ok_q ? ARB : ARP_REQ;
      ARP_REQ: begin
        timer_d = '0;
        state_d = ARP_WAIT;
      end
      ARP_WAIT:
        if (arp_found) begin
          arp_ok_d = 1'b1;
          retry_d  = '0;
          state_d  = ARB;
        end else if (timer_q == ARP_TIMEOUT - 32'd1) begin
          retry_d    = retry_q < ARP_RETRY - 4'd1 ? retry_q + 4'd1 : 4'd0;
          arp_fail_d = retry_q >= ARP_RETRY - 4'd1;
          state_d    = retry_q < ARP_RETRY - 4'd1 ? ARP_REQ : GAP;
        end
      ARB:
        if (arb_valid) begin
          grant_d = arb_gnt;
          sel_d   = arb_gnt == GRANT_CMD;
          len_d   = arb_gnt == GRANT_CMD ? cmd_send_len : AD_PKT_LEN;
          state_d = UDP_REQ;
        end else state_d = IDLE;
      UDP_REQ: begin
        timer_d = '0;
        state_d = UDP_WAIT;
      end
      UDP_WAIT:
        // completion outranks a simultaneous mac_not_exist
        if (mac_send_end) begin
          cmd_ack_d = grant_q == GRANT_CMD;
          ad_ack_d  = grant_q == GRANT_AD;
          state_d   = GAP;
        end else if (mac_not_exist) begin
          arp_ok_d = 1'b0;
          retry_d  = '0;
          state_d  = ARP_REQ;
        end else if (timer_q == TX_TIMEOUT - 32'd1) begin
          tx_timeout = 1'b1;
          state_d    = GAP;
        end
      GAP: if (gap_q + 16'd1 >= IFG_CYCLES) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign arp_request_req      = state_q == ARP_REQ;
  assign udp_tx_req           = state_q == UDP_REQ;
  assign busy                 = state_q != IDLE;
  assign cmd_reply_ack        = cmd_ack_q;
  assign ad_data_ack          = ad_ack_q;
  assign arp_fail             = arp_fail_q;
  assign sel_cmd              = sel_q;
  assign udp_send_data_length = len_q;
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: transaction-level scoreboard with a MAC/requester model around eth_tx_sched
module tb_eth_tx_sched;
  localparam logic [15:0] IFG    = 16'd6;
  localparam logic [31:0] ARP_TO = 32'd100;
  localparam logic [31:0] TX_TO  = 32'd50;
  localparam int EV_ARP = 0, EV_UDP = 1, EV_TMO = 2, EV_CACK = 3, EV_DACK = 4;

  typedef struct {int kind; bit sel; logic [15:0] len;} ev_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_reply_req, ad_data_req, mac_send_end, mac_not_exist, arp_found;
  logic [15:0] cmd_send_len, udp_send_data_length;
  logic cmd_reply_ack, ad_data_ack, udp_tx_req, arp_request_req, sel_cmd, arp_fail, tx_timeout, busy;

  eth_tx_sched #(.AD_PKT_LEN(16'd1024), .IFG_CYCLES(IFG), .ARP_TIMEOUT(ARP_TO),
                 .ARP_RETRY(4'd3), .TX_TIMEOUT(TX_TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_reply_req(cmd_reply_req), .cmd_send_len(cmd_send_len),
    .cmd_reply_ack(cmd_reply_ack), .ad_data_req(ad_data_req), .ad_data_ack(ad_data_ack),
    .udp_tx_req(udp_tx_req), .arp_request_req(arp_request_req),
    .udp_send_data_length(udp_send_data_length), .sel_cmd(sel_cmd), .mac_send_end(mac_send_end),
    .mac_not_exist(mac_not_exist), .arp_found(arp_found), .arp_fail(arp_fail),
    .tx_timeout(tx_timeout), .busy(busy));

  initial forever #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  ev_t exp_q[$];
  logic [15:0] cmd_lens[$];
  int udp_act[$];
  int ad_left = 0, arp_ignore = 0, arp_delay = 0, end_delay = 0, end_cyc = -100;
  int last_udp_cyc = -1, last_arp_cyc = -1, arp_chk = 0, arp_seen = 0;
  bit rr_chk = 0, m_arp_ok = 0, m_last_cmd = 0;

  initial forever @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(int kind, bit sel, logic [15:0] len);
    ev_t e;
    e.kind = kind; e.sel = sel; e.len = len;
    exp_q.push_back(e);
  endtask

  // Service order from the rules: ARP first if unresolved, ties go to the path not served last
  task automatic predict(int na);
    int nc = cmd_lens.size(), ci = 0;
    bit c;
    if (!m_arp_ok) push(EV_ARP, 0, 0);
    m_arp_ok = 1;
    while (nc > 0 || na > 0) begin
      c = (nc > 0 && na > 0) ? !m_last_cmd : (nc > 0);
      push(EV_UDP, c, c ? cmd_lens[ci] : 16'd1024);
      push(c ? EV_CACK : EV_DACK, 0, 0);
      if (c) begin nc--; ci++; end else na--;
      m_last_cmd = c;
    end
  endtask

  task automatic observe(int kind, bit sel, logic [15:0] len);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == EV_UDP) begin
      check("sel_cmd", {31'd0, sel}, {31'd0, e.sel});
      check("udp_len", {16'd0, len}, {16'd0, e.len});
      if (rr_chk && last_udp_cyc >= 0) check("ifg_spacing", {31'd0, (cyc - last_udp_cyc) >= int'(IFG) + 3}, 1);
      last_udp_cyc = cyc;
    end
    if (kind == EV_TMO) check("tmo_latency", cyc - last_udp_cyc, TX_TO);
    if (kind == EV_CACK || kind == EV_DACK) check("ack_latency", cyc - end_cyc, 1);
    if (kind == EV_ARP) begin
      if (arp_chk > 0 && last_arp_cyc >= 0) begin
        check("arp_spacing", cyc - last_arp_cyc, 101);
        arp_chk--;
      end
      last_arp_cyc = cyc;
      arp_seen++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (arp_request_req) observe(EV_ARP, 0, 0);
      if (udp_tx_req) observe(EV_UDP, sel_cmd, udp_send_data_length);
      if (tx_timeout) observe(EV_TMO, 0, 0);
      if (cmd_reply_ack) observe(EV_CACK, 0, 0);
      if (ad_data_ack) observe(EV_DACK, 0, 0);
    end
  end

  initial begin
    cmd_reply_req = 0; ad_data_req = 0; cmd_send_len = 0;
    forever begin
      @(negedge clk);
      if (cmd_reply_ack && cmd_lens.size() > 0) void'(cmd_lens.pop_front());
      if (ad_data_ack && ad_left > 0) ad_left--;
      cmd_reply_req = cmd_lens.size() > 0;
      cmd_send_len = cmd_lens.size() > 0 ? cmd_lens[0] : 16'd0;
      ad_data_req = ad_left > 0;
    end
  end

  // MAC model: udp_act 0 = send_end, 1 = not_exist, 2 = silent
  initial begin
    bit skip = 0;
    int act, d;
    arp_found = 0; mac_send_end = 0; mac_not_exist = 0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 0;
      if (rst_n && arp_request_req) begin
        if (arp_ignore > 0) arp_ignore--;
        else begin
          d = arp_delay > 0 ? arp_delay : int'($urandom_range(2, 20));
          repeat (d - 1) @(negedge clk);
          arp_found = 1; @(negedge clk); arp_found = 0; skip = 1;
        end
      end else if (rst_n && udp_tx_req) begin
        act = udp_act.size() > 0 ? udp_act.pop_front() : 0;
        if (act != 2) begin
          d = end_delay > 0 ? end_delay : int'($urandom_range(2, 20));
          repeat (d - 1) @(negedge clk);
          if (act == 0) begin mac_send_end = 1; end_cyc = cyc; end
          else mac_not_exist = 1;
          @(negedge clk); mac_send_end = 0; mac_not_exist = 0; skip = 1;
        end
      end
    end
  end

  task automatic wait_idle(string name);
    int t = 0;
    while ((exp_q.size() > 0 || busy || cmd_lens.size() > 0 || ad_left > 0) && t < 5000) begin
      @(negedge clk); t++;
    end
    check({name, "_completes"}, {31'd0, t < 5000}, 1);
    exp_q.delete(); cmd_lens.delete(); ad_left = 0;
    repeat (40) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk); rst_n = 1;
    m_arp_ok = 0; m_last_cmd = 0;
  endtask

  initial begin
    logic [15:0] l;
    int t;
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, arp_request_req, udp_tx_req, cmd_reply_ack, ad_data_ack,
          tx_timeout, arp_fail, busy, sel_cmd}, 0);
    check("reset_len", {16'd0, udp_send_data_length}, 0);
    rst_n = 1;
    // ARP exhausts its retries, then a later ARP round succeeds and clears arp_fail
    arp_ignore = 3; arp_chk = 2; last_arp_cyc = -1; arp_seen = 0;
    push(EV_ARP, 0, 0); push(EV_ARP, 0, 0); push(EV_ARP, 0, 0);
    cmd_lens.push_back(16'($urandom));
    predict(0);
    t = 0;
    while (arp_seen < 3 && t < 1000) begin @(negedge clk); t++; end
    check("three_arp_attempts", {31'd0, arp_seen >= 3}, 1);
    while (cyc < last_arp_cyc + 100) @(negedge clk);
    check("arp_fail_before_timeout", {31'd0, arp_fail}, 0);
    @(negedge clk);
    check("arp_fail_set", {31'd0, arp_fail}, 1);
    wait_idle("arp_fail_recovery");
    check("arp_fail_cleared", {31'd0, arp_fail}, 0);
    // Fresh ARP before the first command reply
    do_reset();
    arp_delay = 10; end_delay = 40;
    cmd_lens.push_back(16'd32);
    predict(0);
    wait_idle("arp_first");
    arp_delay = 0; end_delay = 0;
    // Peer vanishes during an AD send: re-ARP, resend, single ack
    udp_act = '{1, 0};
    push(EV_UDP, 0, 16'd1024); push(EV_ARP, 0, 0); push(EV_UDP, 0, 16'd1024); push(EV_DACK, 0, 0);
    m_last_cmd = 0;
    ad_left = 1;
    wait_idle("mac_not_exist");
    // Both paths contending for four packets
    rr_chk = 1; last_udp_cyc = -1;
    if ($urandom_range(0, 1) == 1) begin cmd_lens.push_back(16'd0); cmd_lens.push_back(16'($urandom_range(1, 1500))); end
    else begin cmd_lens.push_back(16'($urandom_range(1, 1500))); cmd_lens.push_back(16'd0); end
    predict(2);
    ad_left = 2;
    wait_idle("round_robin");
    rr_chk = 0;
    // Silent MAC: timeout, no ack, retry after the gap
    l = 16'($urandom);
    udp_act = '{2, 0};
    cmd_lens.push_back(l);
    push(EV_UDP, 1, l); push(EV_TMO, 0, 0); push(EV_UDP, 1, l); push(EV_CACK, 0, 0);
    m_last_cmd = 1;
    wait_idle("tx_timeout");
    // Reset while waiting on the MAC
    l = 16'($urandom_range(1, 16'hFFFF));
    udp_act = '{2};
    cmd_lens.push_back(l);
    push(EV_UDP, 1, l);
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin @(negedge clk); t++; end
    check("udp_before_reset", {31'd0, t < 200}, 1);
    repeat (10) @(negedge clk);
    check("busy_before_reset", {31'd0, busy}, 1);
    #2 rst_n = 0;
    #1;
    check("async_reset_outputs", {24'd0, arp_request_req, udp_tx_req, cmd_reply_ack, ad_data_ack,
          tx_timeout, arp_fail, busy, sel_cmd}, 0);
    check("async_reset_len", {16'd0, udp_send_data_length}, 0);
    udp_act.delete(); exp_q.delete();
    m_arp_ok = 0; m_last_cmd = 0;
    predict(0);
    @(negedge clk); rst_n = 1;
    wait_idle("post_reset_arp");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
